key_space_scheduler: RTL and testbench

- Work scheduler for the multi-core RC4 key-search array.
- Splits the KEY_W-bit secret-key space into equal chunks and hands them to ksa cores on request, with round-robin arbitration.
- Latches the first reported solution and broadcasts stop to all cores.
- Flags exhaustion when every chunk has been searched with no hit.

---
 rtl/key_space_scheduler_if.sv | 34 +++
 rtl/key_space_scheduler.sv | 140 ++++++++++++++
 tb/tb_key_space_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_space_scheduler_if.sv
// Scheduler <-> core-array bus: work dispatch, solution reporting and status.
// The scheduler takes the slave side; the core array (or a bench) takes master.
interface key_space_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 22
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                       start;
    logic [NUM_CORES-1:0]       core_req;
    logic [NUM_CORES-1:0]       core_grant;
    logic [KEY_W-1:0]           chunk_base;
    logic [KEY_W-1:0]           chunk_last;
    logic [NUM_CORES-1:0]       core_found;
    logic [NUM_CORES*KEY_W-1:0] core_found_key;
    logic                       stop;
    logic                       found;
    logic [KEY_W-1:0]           found_key;
    logic [IW-1:0]              found_core;
    logic                       exhausted;
    logic                       busy;

    modport master (
        output start, core_req, core_found, core_found_key,
        input  core_grant, chunk_base, chunk_last, stop, found, found_key,
               found_core, exhausted, busy
    );

    modport slave (
        input  start, core_req, core_found, core_found_key,
        output core_grant, chunk_base, chunk_last, stop, found, found_key,
               found_core, exhausted, busy
    );
endinterface

// File: rtl/key_space_scheduler.sv
// Hands out equal key-space chunks to cracking cores round-robin, latches the
// first reported solution and raises stop on a hit or once the space is spent.
module key_space_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int KEY_W      = 22,
    parameter int CHUNK_LOG2 = 16
) (
    input logic                  CLOCK_50,
    input logic                  reset,
    key_space_scheduler_if.slave bus
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = KEY_W - CHUNK_LOG2 + 1;
    localparam logic [CW-1:0]    NUM_CHUNKS = CW'(1) << (KEY_W - CHUNK_LOG2);
    localparam logic [KEY_W-1:0] CHUNK_SPAN = KEY_W'((64'd1 << CHUNK_LOG2) - 64'd1);

    typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;

    state_t               state, state_d;
    logic [CW-1:0]        chunk_idx;
    logic [IW-1:0]        rr, pick, hit, found_core;
    logic [NUM_CORES-1:0] outstanding, grant_q, grant_d1, elig, done, out_next, pick_oh;
    logic [KEY_W-1:0]     base, hit_key, chunk_base, chunk_last, found_key;
    logic                 chunks_left, pick_vld, hit_vld, do_grant, do_clear;

    assign chunks_left = chunk_idx < NUM_CHUNKS;
    assign base        = KEY_W'(chunk_idx) << CHUNK_LOG2;
    assign pick_oh     = NUM_CORES'(1) << pick;

    // A re-request counts as completion only once the grant is two cycles old,
    // so a request still held from before the grant is not mistaken for done.
    assign done     = outstanding & bus.core_req & ~grant_q & ~grant_d1;
    assign out_next = outstanding & ~done;
    assign elig     = bus.core_req & ~outstanding & ~grant_q & {NUM_CORES{chunks_left}};

    always_comb begin
        int c;
        c        = 0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            c = (int'(rr) + k) % NUM_CORES;
            if (!pick_vld && elig[c]) begin
                pick_vld = 1'b1;
                pick     = IW'(c);
            end
        end
    end

    // Scan downward so the lowest-numbered reporting core wins.
    always_comb begin
        hit_vld = 1'b0;
        hit     = '0;
        hit_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (bus.core_found[i]) begin
                hit_vld = 1'b1;
                hit     = IW'(i);
                hit_key = bus.core_found_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_comb begin
        state_d  = state;
        do_grant = 1'b0;
        do_clear = 1'b0;
        case (state)
            RUN: begin
                if (hit_vld) begin
                    state_d = FOUND;
                end else begin
                    do_grant = pick_vld;
                    // Same-cycle completions count, so exhaustion shows one
                    // cycle after the last core reports back.
                    if (!chunks_left && out_next == '0)
                        state_d = EXHAUSTED;
                end
            end
            IDLE, FOUND, EXHAUSTED: begin
                if (bus.start) begin
                    state_d  = RUN;
                    do_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            chunk_idx   <= '0;
            rr          <= '0;
            outstanding <= '0;
            grant_q     <= '0;
            grant_d1    <= '0;
            chunk_base  <= '0;
            chunk_last  <= '0;
            found_key   <= '0;
            found_core  <= '0;
        end else begin
            state    <= state_d;
            grant_q  <= '0;
            grant_d1 <= grant_q;
            if (do_clear) begin
                chunk_idx   <= '0;
                rr          <= '0;
                outstanding <= '0;
                grant_d1    <= '0;
                found_key   <= '0;
                found_core  <= '0;
            end else if (state == RUN) begin
                if (hit_vld) begin
                    found_key  <= hit_key;
                    found_core <= hit;
                end else if (do_grant) begin
                    grant_q     <= pick_oh;
                    outstanding <= out_next | pick_oh;
                    chunk_idx   <= chunk_idx + 1'b1;
                    rr          <= IW'((int'(pick) + 1) % NUM_CORES);
                    chunk_base  <= base;
                    chunk_last  <= base + CHUNK_SPAN;
                end else begin
                    outstanding <= out_next;
                end
            end
        end
    end

    assign bus.core_grant = grant_q;
    assign bus.chunk_base = chunk_base;
    assign bus.chunk_last = chunk_last;
    assign bus.found_key  = found_key;
    assign bus.found_core = found_core;
    assign bus.busy       = (state == RUN);
    assign bus.found      = (state == FOUND);
    assign bus.exhausted  = (state == EXHAUSTED);
    assign bus.stop       = (state == FOUND) || (state == EXHAUSTED);
endmodule

// File: tb/tb_key_space_scheduler.sv
// Two schedulers (1M-key and 64K-key chunks) driven in lockstep and compared
// every cycle against a cycle-stamped dispatch model, plus directed checks.
module tb_key_space_scheduler;
    localparam int NC = 4;
    localparam int KW = 22;
    localparam int M_IDLE = 0, M_RUN = 1, M_FOUND = 2, M_EXH = 3;

    typedef struct packed {
        logic [3:0]  grant;
        logic [21:0] base;
        logic [21:0] last;
        logic        stop;
        logic        found;
        logic [21:0] fkey;
        logic [1:0]  fcore;
        logic        exh;
        logic        busy;
    } obs_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     req, fnd;
    logic [NC*KW-1:0] keys;
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    key_space_scheduler_if #(.NUM_CORES(NC), .KEY_W(KW)) ifa ();
    key_space_scheduler_if #(.NUM_CORES(NC), .KEY_W(KW)) ifb ();

    assign ifa.start = start;  assign ifa.core_req = req;
    assign ifa.core_found = fnd;  assign ifa.core_found_key = keys;
    assign ifb.start = start;  assign ifb.core_req = req;
    assign ifb.core_found = fnd;  assign ifb.core_found_key = keys;

    key_space_scheduler #(.NUM_CORES(NC), .KEY_W(KW), .CHUNK_LOG2(20)) dut_a (
        .CLOCK_50(clk), .reset(rst), .bus(ifa.slave));
    key_space_scheduler #(.NUM_CORES(NC), .KEY_W(KW), .CHUNK_LOG2(16)) dut_b (
        .CLOCK_50(clk), .reset(rst), .bus(ifb.slave));

    obs_t obs [2];
    assign obs[0] = {ifa.core_grant, ifa.chunk_base, ifa.chunk_last, ifa.stop, ifa.found,
                     ifa.found_key, ifa.found_core, ifa.exhausted, ifa.busy};
    assign obs[1] = {ifb.core_grant, ifb.chunk_base, ifb.chunk_last, ifb.stop, ifb.found,
                     ifb.found_key, ifb.found_core, ifb.exhausted, ifb.busy};

    // Reference state: mode, next chunk number, rr start, chunk owners and
    // the cycle in which each core's latest grant was visible.
    int         mode [2];
    int         nxt  [2];
    int         rr   [2];
    logic [3:0] owns [2];
    int         gcyc [2][4];
    obs_t       exp_o [2];

    always #10 clk = ~clk;

    task automatic check(string name, int j, logic [31:0] got, logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s[%0d] got=%0h want=%0h", name, j, got, want);
        end
    endtask

    task automatic model_reset(int j);
        mode[j] = M_IDLE;
        nxt[j]  = 0;
        rr[j]   = 0;
        owns[j] = '0;
        for (int i = 0; i < NC; i++) gcyc[j][i] = -10;
        exp_o[j] = '0;
    endtask

    task automatic model_step();
        int cl, nch, pick, c;
        logic [3:0] held;
        for (int j = 0; j < 2; j++) begin
            cl  = (j == 0) ? 20 : 16;
            nch = 1 << (KW - cl);
            exp_o[j].grant = 4'h0;
            if (rst) begin
                model_reset(j);
            end else if (mode[j] == M_RUN) begin
                if (fnd != 4'h0) begin
                    pick = -1;
                    for (int i = 0; i < NC; i++) if (pick < 0 && fnd[i]) pick = i;
                    mode[j] = M_FOUND;
                    exp_o[j].fkey  = keys[pick*KW +: KW];
                    exp_o[j].fcore = 2'(pick);
                end else begin
                    held = owns[j];
                    for (int i = 0; i < NC; i++)
                        if (owns[j][i] && req[i] && cyc >= gcyc[j][i] + 2) owns[j][i] = 1'b0;
                    pick = -1;
                    if (nxt[j] < nch)
                        for (int k = 0; k < NC; k++) begin
                            c = (rr[j] + k) % NC;
                            if (pick < 0 && req[c] && !held[c] && gcyc[j][c] != cyc) pick = c;
                        end
                    if (pick >= 0) begin
                        exp_o[j].grant[pick] = 1'b1;
                        exp_o[j].base = 22'(nxt[j] << cl);
                        exp_o[j].last = 22'((nxt[j] << cl) + (1 << cl) - 1);
                        nxt[j]++;
                        rr[j] = (pick + 1) % NC;
                        owns[j][pick] = 1'b1;
                        gcyc[j][pick] = cyc + 1;
                    end else if (nxt[j] >= nch && owns[j] == 4'h0) begin
                        mode[j] = M_EXH;
                    end
                end
            end else if (start) begin
                mode[j] = M_RUN;
                nxt[j]  = 0;
                rr[j]   = 0;
                owns[j] = '0;
                for (int i = 0; i < NC; i++) gcyc[j][i] = -10;
                exp_o[j].fkey  = '0;
                exp_o[j].fcore = '0;
            end
            exp_o[j].busy  = (mode[j] == M_RUN);
            exp_o[j].found = (mode[j] == M_FOUND);
            exp_o[j].exh   = (mode[j] == M_EXH);
            exp_o[j].stop  = (mode[j] == M_FOUND) || (mode[j] == M_EXH);
        end
        cyc++;
    endtask

    task automatic chk_all();
        for (int j = 0; j < 2; j++) begin
            check("grant", j, obs[j].grant, exp_o[j].grant);
            check("chunk_base", j, obs[j].base, exp_o[j].base);
            check("chunk_last", j, obs[j].last, exp_o[j].last);
            check("stop", j, obs[j].stop, exp_o[j].stop);
            check("found", j, obs[j].found, exp_o[j].found);
            check("found_key", j, obs[j].fkey, exp_o[j].fkey);
            check("found_core", j, obs[j].fcore, exp_o[j].fcore);
            check("exhausted", j, obs[j].exh, exp_o[j].exh);
            check("busy", j, obs[j].busy, exp_o[j].busy);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk_all();
    endtask

    logic [25:0] qa [$];
    logic [21:0] qb [$];
    logic        seen;

    initial begin
        rst = 1'b1; start = 1'b0; req = '0; fnd = '0; keys = '0;
        model_reset(0);
        model_reset(1);
        #5;
        chk_all();
        step();
        step();
        rst = 1'b0;

        // All four cores request and hold: round-robin over the 4 big chunks.
        start = 1'b1; step(); start = 1'b0;
        req = 4'hF;
        for (int n = 0; n < 10; n++) begin
            step();
            if (ifa.core_grant != 4'h0) qa.push_back({ifa.core_grant, ifa.chunk_base});
        end
        check("grants_a", 0, qa.size(), 4);
        for (int k = 0; k < qa.size(); k++)
            check("order_a", k, qa[k], {4'(1 << k), 22'(k << 20)});
        check("exh_a", 0, ifa.exhausted, 1'b1);
        check("exh_stop_a", 0, ifa.stop, 1'b1);

        // Simultaneous hits from cores 1 and 3; lower index wins and sticks.
        start = 1'b1; step(); start = 1'b0;
        for (int n = 0; n < 3; n++) step();
        fnd = 4'b1010;
        keys = '0;
        keys[1*KW +: KW] = 22'h0ABCDE;
        keys[3*KW +: KW] = 22'h123456;
        step();
        fnd = 4'b0000;
        check("hit_found", 0, ifa.found, 1'b1);
        check("hit_core", 0, ifa.found_core, 2'd1);
        check("hit_key", 0, ifa.found_key, 22'h0ABCDE);
        check("hit_stop", 0, ifa.stop, 1'b1);
        check("hit_key", 1, ifb.found_key, 22'h0ABCDE);
        fnd = 4'b0001;
        keys[0 +: KW] = 22'h3FFFFF;
        step();
        fnd = 4'b0000;
        check("hit_hold_key", 0, ifa.found_key, 22'h0ABCDE);
        check("hit_hold_core", 0, ifa.found_core, 2'd1);

        // Restart from FOUND clears everything; first new grant is chunk 0.
        start = 1'b1; step(); start = 1'b0;
        check("restart_stop", 0, ifa.stop, 1'b0);
        check("restart_found", 0, ifa.found, 1'b0);
        check("restart_key", 0, ifa.found_key, 22'h0);
        req = 4'hF;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            if (ifa.core_grant != 4'h0) begin
                seen = 1'b1;
                check("restart_base", 0, ifa.chunk_base, 22'h0);
            end
        end
        check("restart_seen", 0, seen, 1'b1);

        // Asynchronous reset with a grant scheduled for the next edge.
        step();
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        chk_all();
        check("rst_grant", 1, ifb.core_grant, 4'h0);
        check("rst_busy", 1, ifb.busy, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Core 2 alone, then a tie against core 0 resolved by the rr pointer.
        req = 4'b0100;
        start = 1'b1; step(); start = 1'b0;
        for (int n = 0; n < 40 && qb.size() < 3; n++) begin
            step();
            if (ifb.core_grant != 4'h0) begin
                check("c2_only", 1, ifb.core_grant, 4'b0100);
                qb.push_back(ifb.chunk_base);
            end
        end
        check("c2_count", 1, qb.size(), 3);
        for (int k = 0; k < qb.size(); k++)
            check("c2_base", k, qb[k], 22'(k << 16));
        req = 4'b0000; step(); step();
        req = 4'b0100; step();
        req = 4'b0101; step();
        check("rr_first", 1, ifb.core_grant, 4'b0001);
        step();
        check("rr_second", 1, ifb.core_grant, 4'b0100);

        // Random traffic with occasional restarts and hits.
        for (int n = 0; n < 400; n++) begin
            req   = 4'($urandom);
            fnd   = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'h0;
            keys  = 88'({$urandom(), $urandom(), $urandom()});
            start = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
